// File: rtl/alu_cla_pipe.sv
// Two-stage pipelined ALU (AND/OR/ADD/SUB/SLT/NOR) built from per-bit p/g slices
// and a block carry-lookahead tree, with valid/ready handshakes on both sides.
module alu_cla_pipe #(
  parameter int WIDTH     = 32,
  parameter int CLA_BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int NG = WIDTH / CLA_BLOCK;

  if ((WIDTH < 2) || ((WIDTH % CLA_BLOCK) != 0) ||
      !((CLA_BLOCK == 2) || (CLA_BLOCK == 4) || (CLA_BLOCK == 8))) begin : g_bad_param
    $error("alu_cla_pipe: illegal WIDTH/CLA_BLOCK combination");
  end

  // ---------------- handshake ----------------
  logic s1_valid_q, s2_valid_q;
  logic s2_ready, s1_ready, s1_load, s2_load;

  assign s2_ready  = ~s2_valid_q | out_ready;
  assign s1_ready  = ~s1_valid_q | s2_ready;
  assign in_ready  = s1_ready;
  assign s1_load   = in_valid & s1_ready;
  assign s2_load   = s1_valid_q & s2_ready;
  assign out_valid = s2_valid_q;

  // ---------------- stage 1: operands, bit p/g, group lookahead ----------------
  logic [WIDTH-1:0] a_d, b_d, g_bit, p_bit;
  logic             cin_d;
  logic [NG-1:0]    grp_g, grp_p;
  logic [NG:0]      grp_c_d;

  assign a_d   = ctrl[3] ? ~src1 : src1;
  assign b_d   = ctrl[2] ? ~src2 : src2;
  assign cin_d = ctrl[2];
  assign g_bit = a_d & b_d;
  assign p_bit = a_d | b_d;

  always_comb begin : group_pg
    logic gg, pp;
    grp_g = '0;
    grp_p = '0;
    for (int j = 0; j < NG; j++) begin
      gg = 1'b0;
      pp = 1'b1;
      for (int k = 0; k < CLA_BLOCK; k++) begin
        gg = g_bit[j*CLA_BLOCK+k] | (p_bit[j*CLA_BLOCK+k] & gg);
        pp = pp & p_bit[j*CLA_BLOCK+k];
      end
      grp_g[j] = gg;
      grp_p[j] = pp;
    end
  end

  // Each group carry is a flat sum of products of group G/P and cin, so no
  // group carry waits on the one below it.
  always_comb begin : group_carry
    logic acc, prod;
    grp_c_d = '0;
    for (int j = 0; j <= NG; j++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int k = j - 1; k >= 0; k--) begin
        acc  = acc | (prod & grp_g[k]);
        prod = prod & grp_p[k];
      end
      grp_c_d[j] = acc | (prod & cin_d);
    end
  end

  // grp_c_q[0] is the registered cin; grp_c_q[NG] is the final carry-out.
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;
  logic [NG:0]      grp_c_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of always_ff evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      grp_c_q    <= '0;
    end else begin
      if (s1_ready) s1_valid_q <= in_valid;
      if (s1_load) begin
        a_q     <= a_d;
        b_q     <= b_d;
        op_q    <= ctrl[1:0];
        grp_c_q <= grp_c_d;
      end
    end
  end

  // ---------------- stage 2: in-group carries, sum, mux, flags ----------------
  logic [WIDTH:0]   c_s2;
  logic [WIDTH-1:0] g_s2, p_s2, sum_s2, res_d;
  logic             ovf_s2, cout_d, ovf_d, zero_d;

  assign g_s2 = a_q & b_q;
  assign p_s2 = a_q | b_q;

  always_comb begin : bit_carry
    logic carry;
    c_s2 = '0;
    for (int j = 0; j < NG; j++) begin
      carry = grp_c_q[j];
      for (int k = 0; k < CLA_BLOCK; k++) begin
        c_s2[j*CLA_BLOCK+k] = carry;
        carry = g_s2[j*CLA_BLOCK+k] | (p_s2[j*CLA_BLOCK+k] & carry);
      end
    end
    c_s2[WIDTH] = grp_c_q[NG];
  end

  assign sum_s2 = a_q ^ b_q ^ c_s2[WIDTH-1:0];
  assign ovf_s2 = c_s2[WIDTH] ^ c_s2[WIDTH-1];

  always_comb begin
    res_d = '0;
    unique case (op_q)
      2'b00:   res_d = a_q & b_q;
      2'b01:   res_d = a_q | b_q;
      2'b10:   res_d = sum_s2;
      default: res_d = {{(WIDTH-1){1'b0}}, sum_s2[WIDTH-1] ^ ovf_s2};
    endcase
  end

  assign cout_d = op_q[1] & c_s2[WIDTH];
  assign ovf_d  = op_q[1] & ovf_s2;
  assign zero_d = (res_d == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      result     <= '0;
      zero       <= 1'b0;
      cout       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (s2_ready) s2_valid_q <= s1_valid_q;
      if (s2_load) begin
        result   <= res_d;
        zero     <= zero_d;
        cout     <= cout_d;
        overflow <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_alu_cla_pipe.sv
// Scoreboard bench for alu_cla_pipe: directed vectors push expected results,
// an independent monitor pops and compares on every output transfer.
module tb_alu_cla_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1, src2;
  logic [3:0]  ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero, cout, overflow;

  alu_cla_pipe #(.WIDTH(32), .CLA_BLOCK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .ctrl(ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compare every output transfer against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {32'd0, result}, 64'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", {32'd0, result}, {32'd0, e.res});
        check("flags_zcv", {61'd0, zero, cout, overflow}, {61'd0, e.z, e.c, e.v});
      end
    end
  end

  // Present one op and hold until accepted; in_valid stays high for back-to-back use.
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic z, input logic co, input logic v);
    bit ok;
    sb.push_back('{res: r, z: z, c: co, v: v});
    in_valid = 1'b1;
    ctrl     = c;
    src1     = a;
    src2     = b;
    ok       = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    src1     = 32'h0;
    src2     = 32'h0;
    ctrl     = 4'h0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  logic [31:0] held;

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    idle();
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_outputs", {29'd0, result, zero, cout, overflow}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: signed overflow on ADD, plus 2-cycle latency
    send(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    check("latency_cycle1_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check("latency_cycle2_out_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;

    // T2..T4 and extras, issued back to back with out_ready high
    send(4'b0110, 32'd5,          32'd5,          32'd0,          1'b1, 1'b1, 1'b0);
    send(4'b0110, 32'h8000_0000, 32'd1,          32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
    send(4'b0111, 32'hFFFF_FFFF, 32'd1,          32'd1,          1'b0, 1'b1, 1'b0);
    send(4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1,          1'b0, 1'b1, 1'b1);
    send(4'b0111, 32'd1,          32'hFFFF_FFFF, 32'd0,          1'b1, 1'b0, 1'b0);
    send(4'b0111, 32'd7,          32'd7,          32'd0,          1'b1, 1'b1, 1'b0);
    send(4'b1100, 32'hF0F0_F0F0, 32'h0F0F_0F00, 32'h0000_000F, 1'b0, 1'b0, 1'b0);
    send(4'b0001, 32'hF0F0_F0F0, 32'h0F0F_0F00, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0);
    send(4'b0000, 32'hF0F0_F0F0, 32'h0F0F_0F00, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    send(4'b0010, 32'hFFFF_FFFF, 32'd1,          32'd0,          1'b1, 1'b1, 1'b0);
    idle();
    wait_drain();

    // T5: backpressure with 4 back-to-back ops
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin
        send(4'b0010, 32'd10,   32'd20,   32'd30,   1'b0, 1'b0, 1'b0);
        send(4'b0110, 32'd100,  32'd1,    32'd99,   1'b0, 1'b1, 1'b0);
        send(4'b0001, 32'hA0,   32'h0B,   32'hAB,   1'b0, 1'b0, 1'b0);
        send(4'b0000, 32'hFF,   32'h3C,   32'h3C,   1'b0, 1'b0, 1'b0);
        idle();
      end
      begin
        bit full;
        full = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (!in_ready) begin full = 1'b1; break; end
        end
        check("stall_in_ready_low", {63'd0, full}, 64'd1);
        held = result;
        check("stall_first_result", {32'd0, held}, 64'd30);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall_hold", {31'd0, out_valid, result}, {31'd0, 1'b1, held});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // T6: reset with two ops in flight
    @(posedge clk); #1;
    send(4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
    send(4'b0010, 32'd4, 32'd4, 32'd8, 1'b0, 1'b0, 1'b0);
    idle();
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_outputs", {29'd0, result, zero, cout, overflow}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("post_rst_cycle1_out_valid", {63'd0, out_valid}, 64'd0);
    wait_drain();
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
